// File: rtl/max_pool_2x2_if.sv
// Pixel stream interface between the ReLU stage and the 2x2 max-pool stage.
// The master side drives pixels and start; the slave side returns pooled results.
interface max_pool_2x2_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  start;
   logic                  data_valid;
   logic [DATA_WIDTH-1:0] data_in;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  data_out_valid;
   logic                  frame_done;
   logic                  busy;

   modport master (
      output start, data_valid, data_in,
      input  data_out, data_out_valid, frame_done, busy
   );

   modport slave (
      input  start, data_valid, data_in,
      output data_out, data_out_valid, frame_done, busy
   );
endinterface

// File: rtl/max_pool_2x2.sv
// Streaming 2x2 stride-2 signed max-pool. Horizontal pair maxima of even rows are held
// in a half-width line buffer and merged with the odd row's pair maxima.
module max_pool_2x2 #(
   parameter int DATA_WIDTH = 32,
   parameter int IMG_WIDTH  = 8,
   parameter int IMG_HEIGHT = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   max_pool_2x2_if.slave  bus
);
   localparam int COL_W    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam int ROW_W    = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam int LB_DEPTH = IMG_WIDTH / 2;
   localparam int LB_W     = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      EVEN_ROW = 2'd1,
      ODD_ROW  = 2'd2
   } state_t;

   state_t                        state_r;
   logic [COL_W-1:0]              col_r;
   logic [ROW_W-1:0]              row_r;
   logic signed [DATA_WIDTH-1:0]  h_reg_r;
   logic signed [DATA_WIDTH-1:0]  lbuf_r [0:LB_DEPTH-1];
   logic signed [DATA_WIDTH-1:0]  data_out_r;
   logic                          data_out_valid_r;
   logic                          frame_done_r;
   logic                          busy_r;

   logic signed [DATA_WIDTH-1:0]  din_s;
   logic signed [DATA_WIDTH-1:0]  hmax_s;
   logic signed [DATA_WIDTH-1:0]  win_max_s;
   logic [LB_W-1:0]               lb_idx_s;
   logic                          accept_s;
   logic                          last_col_s;
   logic                          last_px_s;
   logic                          out_fire_s;
   logic                          lb_wr_s;
   logic                          h_wr_s;

   // Datapath maxima and accept/qualify decode; a start discards the concurrent pixel
   // unless it is the frame's final pixel.
   always_comb begin
      din_s      = $signed(bus.data_in);
      accept_s   = bus.data_valid && (state_r != IDLE);
      last_col_s = (col_r == COL_LAST);
      last_px_s  = last_col_s && (row_r == ROW_LAST);
      hmax_s     = (din_s > h_reg_r) ? din_s : h_reg_r;
      lb_idx_s   = LB_W'(col_r >> 1);
      win_max_s  = (lbuf_r[lb_idx_s] > hmax_s) ? lbuf_r[lb_idx_s] : hmax_s;
      out_fire_s = accept_s && (state_r == ODD_ROW) && col_r[0] && (!bus.start || last_px_s);
      lb_wr_s    = accept_s && !bus.start && (state_r == EVEN_ROW) && col_r[0];
      h_wr_s     = accept_s && !bus.start && !col_r[0];
   end

   // Line buffer of even-row pair maxima; always written before it is read.
   always_ff @(posedge clk) begin
      if (lb_wr_s) begin
         lbuf_r[lb_idx_s] <= hmax_s;
      end
   end

   // Frame FSM, raster counters, horizontal register and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r          <= IDLE;
         col_r            <= COL_W'(0);
         row_r            <= ROW_W'(0);
         h_reg_r          <= DATA_WIDTH'(0);
         data_out_r       <= DATA_WIDTH'(0);
         data_out_valid_r <= 1'b0;
         frame_done_r     <= 1'b0;
         busy_r           <= 1'b0;
      end else begin
         data_out_valid_r <= 1'b0;
         frame_done_r     <= 1'b0;
         if (out_fire_s) begin
            data_out_r       <= win_max_s;
            data_out_valid_r <= 1'b1;
            frame_done_r     <= last_px_s;
         end
         if (h_wr_s) begin
            h_reg_r <= din_s;
         end
         if (bus.start) begin
            state_r <= EVEN_ROW;
            col_r   <= COL_W'(0);
            row_r   <= ROW_W'(0);
            busy_r  <= 1'b1;
         end else begin
            case (state_r)
               IDLE: begin
                  busy_r <= 1'b0;
               end
               EVEN_ROW, ODD_ROW: begin
                  if (bus.data_valid) begin
                     if (last_px_s) begin
                        state_r <= IDLE;
                        col_r   <= COL_W'(0);
                        row_r   <= ROW_W'(0);
                        busy_r  <= 1'b0;
                     end else if (last_col_s) begin
                        col_r   <= COL_W'(0);
                        row_r   <= row_r + ROW_W'(1);
                        state_r <= row_r[0] ? EVEN_ROW : ODD_ROW;
                     end else begin
                        col_r <= col_r + COL_W'(1);
                     end
                  end
               end
               default: begin
                  state_r <= IDLE;
                  col_r   <= COL_W'(0);
                  row_r   <= ROW_W'(0);
                  busy_r  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.data_out       = data_out_r;
   assign bus.data_out_valid = data_out_valid_r;
   assign bus.frame_done     = frame_done_r;
   assign bus.busy           = busy_r;
endmodule

// File: tb/tb_max_pool_2x2.sv
// Self-checking bench for max_pool_2x2 on a 4x4 frame: a frame-array reference model
// is compared every cycle, and hand-computed pooled lists pin the model per scenario.
module tb_max_pool_2x2;
   localparam int DW   = 32;
   localparam int W    = 4;
   localparam int H    = 4;
   localparam int NPIX = W * H;

   logic clk;
   logic rst_n;
   max_pool_2x2_if #(.DATA_WIDTH(DW)) bus ();

   max_pool_2x2 #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int pass_cnt;
   int total_cnt;

   // reference model: pixel storage by raster index, frame position, last output
   int          fr [0:NPIX-1];
   logic        m_active;
   int          m_idx;
   logic [31:0] m_last;

   // expectations valid between the last clock edge and the next
   logic        exp_v;
   logic        exp_done;
   logic        exp_busy;
   logic [31:0] exp_val;
   logic        chk_en;

   logic [31:0] got [$];
   logic [31:0] want [$];
   int          done_cnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act !== exp) begin
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end else begin
         pass_cnt++;
      end
   endtask

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // store one accepted pixel; if it closes a 2x2 window report the window maximum
   task automatic model_accept(input int d, output logic nv, output logic [31:0] nval,
                               output logic nd);
      int r;
      int c;
      nv   = 1'b0;
      nd   = 1'b0;
      nval = m_last;
      fr[m_idx] = d;
      r = m_idx / W;
      c = m_idx % W;
      if ((r % 2 == 1) && (c % 2 == 1)) begin
         nv   = 1'b1;
         nval = max2(max2(fr[(r-1)*W + c-1], fr[(r-1)*W + c]),
                     max2(fr[r*W + c-1], fr[r*W + c]));
         nd   = (m_idx == NPIX - 1);
      end
      m_idx++;
      if (m_idx == NPIX) begin
         m_active = 1'b0;
         m_idx    = 0;
      end
   endtask

   // drive one clock of inputs, advance the model, publish expectations after the edge
   task automatic step(input logic s, input logic v, input int d);
      logic        nv;
      logic        nd;
      logic [31:0] nval;
      nv   = 1'b0;
      nd   = 1'b0;
      nval = m_last;
      bus.start      = s;
      bus.data_valid = v;
      bus.data_in    = d;
      if (rst_n) begin
         if (m_active && v && (!s || m_idx == NPIX - 1)) begin
            model_accept(d, nv, nval, nd);
         end
         if (s) begin
            m_active = 1'b1;
            m_idx    = 0;
         end
      end
      @(posedge clk);
      #1;
      bus.start      = 1'b0;
      bus.data_valid = 1'b0;
      if (nv) m_last = nval;
      exp_v    = nv;
      exp_done = nd;
      exp_busy = m_active;
      exp_val  = m_last;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, 0);
   endtask

   task automatic ramp(input int base);
      for (int k = 0; k < NPIX; k++) step(1'b0, 1'b1, base + k);
   endtask

   task automatic clear_got();
      got.delete();
      done_cnt = 0;
   endtask

   // compare collected pooled values and frame_done count with a hand-computed list
   task automatic check_got(input string name, input int exp_done_cnt);
      check({name, "_count"}, got.size(), want.size());
      for (int k = 0; k < want.size(); k++) begin
         if (k < got.size()) check({name, "_value"}, got[k], want[k]);
      end
      check({name, "_frame_done"}, done_cnt, exp_done_cnt);
      check({name, "_busy_after"}, bus.busy, 1'b0);
      clear_got();
   endtask

   task automatic model_reset();
      m_active = 1'b0;
      m_idx    = 0;
      m_last   = 32'd0;
      exp_v    = 1'b0;
      exp_done = 1'b0;
      exp_busy = 1'b0;
      exp_val  = 32'd0;
   endtask

   task automatic compare_loop();
      forever begin
         @(negedge clk);
         if (chk_en) begin
            check("data_out_valid", bus.data_out_valid, exp_v);
            check("frame_done", bus.frame_done, exp_done);
            check("busy", bus.busy, exp_busy);
            check("data_out", bus.data_out, exp_val);
            if (bus.data_out_valid) got.push_back(bus.data_out);
            if (bus.frame_done) done_cnt++;
         end
      end
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      chk_en    = 1'b0;
      done_cnt  = 0;
      rst_n     = 1'b0;
      bus.start      = 1'b0;
      bus.data_valid = 1'b0;
      bus.data_in    = 32'd0;
      model_reset();
      fork
         compare_loop();
      join_none
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("reset_data_out", bus.data_out, 32'd0);
      check("reset_valid", bus.data_out_valid, 1'b0);
      check("reset_frame_done", bus.frame_done, 1'b0);
      check("reset_busy", bus.busy, 1'b0);
      chk_en = 1'b1;

      // data_valid while idle is ignored
      step(1'b0, 1'b1, 55);
      idle(1);

      // ramp
      step(1'b1, 1'b0, 0);
      ramp(0);
      idle(3);
      want = {32'd5, 32'd7, 32'd13, 32'd15};
      check_got("ramp", 1);

      // signed values and ties
      step(1'b1, 1'b0, 0);
      for (int k = 0; k < NPIX; k++) begin
         step(1'b0, 1'b1, (k == 6) ? -1 : ((k == 9) ? 32'h7FFF_FFFF : -3));
      end
      idle(3);
      want = {32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFD};
      check_got("signed", 1);

      // gapped input
      step(1'b1, 1'b0, 0);
      for (int k = 0; k < NPIX; k++) begin
         step(1'b0, 1'b1, k);
         step(1'b0, 1'b0, 0);
         if (k == 9) idle(10);
      end
      idle(3);
      want = {32'd5, 32'd7, 32'd13, 32'd15};
      check_got("gapped", 1);

      // abort: the pixel presented with the second start is discarded
      step(1'b1, 1'b0, 0);
      for (int k = 0; k < 6; k++) step(1'b0, 1'b1, 200 + k);
      step(1'b1, 1'b1, 999);
      clear_got();
      ramp(0);
      idle(3);
      want = {32'd5, 32'd7, 32'd13, 32'd15};
      check_got("abort", 1);

      // reset mid-frame after pixel 9
      step(1'b1, 1'b0, 0);
      for (int k = 0; k < 10; k++) step(1'b0, 1'b1, k);
      rst_n = 1'b0;
      model_reset();
      #1;
      check("midrst_data_out", bus.data_out, 32'd0);
      check("midrst_valid", bus.data_out_valid, 1'b0);
      check("midrst_frame_done", bus.frame_done, 1'b0);
      check("midrst_busy", bus.busy, 1'b0);
      step(1'b0, 1'b1, 77);
      step(1'b0, 1'b1, 78);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 300 + k);
      clear_got();
      step(1'b1, 1'b0, 0);
      ramp(0);
      idle(3);
      want = {32'd5, 32'd7, 32'd13, 32'd15};
      check_got("reset_midframe", 1);

      // back-to-back frames, start coincident with the final pixel
      step(1'b1, 1'b0, 0);
      for (int k = 0; k < NPIX - 1; k++) step(1'b0, 1'b1, k);
      step(1'b1, 1'b1, 15);
      ramp(100);
      idle(3);
      want = {32'd5, 32'd7, 32'd13, 32'd15, 32'd105, 32'd107, 32'd113, 32'd115};
      check_got("back_to_back", 2);

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
